// File: rtl/hue_wheel_pwm.sv
// hue_wheel_pwm: colour-wheel generator. A six-sector FSM with a ramp counter
// sweeps the hue circle. Three free-running PWM comparators drive active-high
// red/green/blue enables. Each channel's duty reloads only at the PWM period boundary.
module hue_wheel_pwm #(
  parameter int PWM_BITS    = 8,
  parameter int STEP_CYCLES = 7812
) (
  input  logic                clk,
  input  logic                reset,
  output logic                red,
  output logic                green,
  output logic                blue,
  output logic [2:0]          sector,
  output logic [PWM_BITS-1:0] ramp
);

  localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [PWM_BITS-1:0] MAX       = '1;
  localparam logic [SW-1:0]       STEP_LAST = SW'(STEP_CYCLES - 1);

  localparam logic [2:0] S0 = 3'd0;
  localparam logic [2:0] S1 = 3'd1;
  localparam logic [2:0] S2 = 3'd2;
  localparam logic [2:0] S3 = 3'd3;
  localparam logic [2:0] S4 = 3'd4;
  localparam logic [2:0] S5 = 3'd5;

  logic [SW-1:0]       step_cnt_q, step_cnt_d;
  logic [2:0]          sector_q, sector_d;
  logic [PWM_BITS-1:0] ramp_q, ramp_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0] duty_r_q, duty_r_d;
  logic [PWM_BITS-1:0] duty_g_q, duty_g_d;
  logic [PWM_BITS-1:0] duty_b_q, duty_b_d;
  logic                red_q, red_d;
  logic                green_q, green_d;
  logic                blue_q, blue_d;
  logic [PWM_BITS-1:0] tgt_r, tgt_g, tgt_b;
  logic [PWM_BITS-1:0] ramp_inv;
  logic                tick;

  // Step timer and PWM counter, both free-running and wrapping
  always_comb begin
    tick       = (step_cnt_q == STEP_LAST);
    step_cnt_d = tick ? '0 : step_cnt_q + SW'(1);
    pwm_cnt_d  = pwm_cnt_q + PWM_BITS'(1);
  end

  // Sector FSM state register (ramp travels with it)
  always_ff @(posedge clk) begin
    if (reset) begin
      sector_q <= S0;
      ramp_q   <= '0;
    end else begin
      sector_q <= sector_d;
      ramp_q   <= ramp_d;
    end
  end

  // Sector FSM next state: advance ramp on tick, roll sector at ramp MAX
  always_comb begin
    sector_d = sector_q;
    ramp_d   = ramp_q;
    if (tick) begin
      if (sector_q > S5) begin
        // codes 6/7 are unreachable; recover cleanly to the start of the wheel
        sector_d = S0;
        ramp_d   = '0;
      end else if (ramp_q == MAX) begin
        ramp_d   = '0;
        sector_d = (sector_q == S5) ? S0 : sector_q + 3'd1;
      end else begin
        ramp_d   = ramp_q + PWM_BITS'(1);
      end
    end
  end

  // Sector FSM outputs: target duties per sector
  always_comb begin
    ramp_inv = MAX - ramp_q;
    tgt_r    = '0;
    tgt_g    = '0;
    tgt_b    = '0;
    case (sector_q)
      S0: begin tgt_r = MAX;      tgt_g = ramp_q;   tgt_b = '0;       end
      S1: begin tgt_r = ramp_inv; tgt_g = MAX;      tgt_b = '0;       end
      S2: begin tgt_r = '0;       tgt_g = MAX;      tgt_b = ramp_q;   end
      S3: begin tgt_r = '0;       tgt_g = ramp_inv; tgt_b = MAX;      end
      S4: begin tgt_r = ramp_q;   tgt_g = '0;       tgt_b = MAX;      end
      S5: begin tgt_r = MAX;      tgt_g = '0;       tgt_b = ramp_inv; end
      default: begin tgt_r = '0;  tgt_g = '0;       tgt_b = '0;       end
    endcase
  end

  // Duty reload only on the last PWM count, then registered compare per channel
  always_comb begin
    duty_r_d = duty_r_q;
    duty_g_d = duty_g_q;
    duty_b_d = duty_b_q;
    if (pwm_cnt_q == MAX) begin
      duty_r_d = tgt_r;
      duty_g_d = tgt_g;
      duty_b_d = tgt_b;
    end
    red_d   = (pwm_cnt_q < duty_r_q);
    green_d = (pwm_cnt_q < duty_g_q);
    blue_d  = (pwm_cnt_q < duty_b_q);
  end

  // Datapath registers: timers, duties, outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      step_cnt_q <= '0;
      pwm_cnt_q  <= '0;
      duty_r_q   <= MAX;
      duty_g_q   <= '0;
      duty_b_q   <= '0;
      red_q      <= 1'b0;
      green_q    <= 1'b0;
      blue_q     <= 1'b0;
    end else begin
      step_cnt_q <= step_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      duty_r_q   <= duty_r_d;
      duty_g_q   <= duty_g_d;
      duty_b_q   <= duty_b_d;
      red_q      <= red_d;
      green_q    <= green_d;
      blue_q     <= blue_d;
    end
  end

  assign red    = red_q;
  assign green  = green_q;
  assign blue   = blue_q;
  assign sector = sector_q;
  assign ramp   = ramp_q;

endmodule

// File: doc/hue_wheel_pwm.md
# hue_wheel_pwm

Colour-wheel generator that feeds the board top level. It produces the active-high `red`, `green` and `blue` LED enables; the top level inverts them onto the active-low RGB pins. The block sweeps smoothly through the full hue circle using a six-sector FSM and a ramp counter. Each channel is driven by a free-running PWM comparator whose duty is updated only at PWM-period boundaries.

## Interface
- `PWM_BITS`, default 8: PWM and ramp resolution. Define MAX = 2^PWM_BITS-1.
- `STEP_CYCLES`, default 7812: clock cycles per ramp step. Must be ≥1. At 12 MHz this gives a ≈1 s full wheel.
- `clk`  in  1  system clock. One clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `red`  out  1  red LED enable, 1 = lit. Registered.
- `green`  out  1  green LED enable, 1 = lit. Registered.
- `blue`  out  1  blue LED enable, 1 = lit. Registered.
- `sector`  out  3  current hue sector, 0..5. Used for debug and verification.
- `ramp`  out  PWM_BITS  current ramp value within the sector.

## Operation
- **Step timer**
  - `step_cnt` counts 0..STEP_CYCLES-1 and wraps to 0.
  - `tick` is asserted in the cycle where `step_cnt` = STEP_CYCLES-1.
- **Ramp and sector**
  - On `tick`, `ramp` increments.
  - On `tick` with `ramp` = MAX: `ramp` goes to 0 and `sector` advances, 0→1→…→5→0.
  - `ramp` and `sector` change on no other condition.
- **Sector FSM, target duties (R, G, B)**
  - S0: MAX, ramp, 0
  - S1: MAX-ramp, MAX, 0
  - S2: 0, MAX, ramp
  - S3: 0, MAX-ramp, MAX
  - S4: ramp, 0, MAX
  - S5: MAX, 0, MAX-ramp
  - Sector codes 6 and 7 are unreachable. If ever entered, the next `tick` forces sector 0 and ramp 0.
- **Duty registers**
  - `duty_r`, `duty_g`, `duty_b` (PWM_BITS wide) load the target duties only in the cycle where `pwm_cnt` = MAX.
  - Duty is therefore constant across each PWM period. Sector/ramp changes that occur mid-period take effect at the next period.
- **PWM**
  - `pwm_cnt` is PWM_BITS wide, free-running, increments every cycle and wraps MAX→0.
  - Each output is registered: `red` <= (`pwm_cnt` < `duty_r`); likewise for `green` and `blue`.
  - The compare is unsigned, with no extension.
  - Duty 0 gives a constant 0. Duty MAX gives high for MAX of every 2^PWM_BITS cycles.
- **Arithmetic**
  - MAX-ramp is computed in PWM_BITS width and never underflows.
  - `step_cnt` width is $clog2(STEP_CYCLES), minimum 1.

## Timing
- **Reset** (any cycle `reset` is sampled high, including mid-sweep):
  - `step_cnt` = 0, `pwm_cnt` = 0, `sector` = 0, `ramp` = 0.
  - `duty_r` = MAX, `duty_g` = 0, `duty_b` = 0.
  - `red` = `green` = `blue` = 0.
- **After reset release**
  - First edge: `red` = 1, `green` = 0, `blue` = 0.
  - The first PWM period runs with sector-0 duties.
- **Latencies**
  - Duty register to output: 1 cycle.
  - Sector/ramp change to output: up to 2^PWM_BITS+1 cycles, because duties load only at the period boundary.
- **Rates**
  - One sector = (MAX+1)·STEP_CYCLES cycles.
  - Full wheel = 6·(MAX+1)·STEP_CYCLES cycles.
- **Simultaneous events**
  - `tick` coincident with `pwm_cnt` = MAX: the duty load uses the pre-tick `sector`/`ramp`.
  - `tick` at MAX ramp coincident with `reset`: reset wins.
- **Edge cases**
  - STEP_CYCLES = 1: `tick` is asserted every cycle.
  - Sector boundaries are continuous: the duties at the end of sector n equal the duties at the start of sector n+1, with no step discontinuity.

## Test plan
- **Reset mid-sweep.** PWM_BITS=3, STEP_CYCLES=2. Run 50 cycles, hold `reset` for 3 cycles, then release. Required: outputs 0 while in reset; `sector`=0 and `ramp`=0; first edge after release shows red=1, green=0, blue=0.
- **Duty at sector 0 start.** Defaults, sector 0, ramp 0. Required: red high exactly 255 of every 256 cycles; green and blue stay 0.
- **Sector advance.** PWM_BITS=3, STEP_CYCLES=2. Required: `sector` goes 0→1 exactly 16 cycles after release; after 96 cycles it returns to sector 0, ramp 0.
- **Period-boundary duty.** PWM_BITS=3, STEP_CYCLES=1, sector 0. Required: in each 8-cycle PWM period, the green high count equals `ramp` as sampled at `pwm_cnt`=7 of the prior period; no period shows a mixed duty.
- **Continuity.** PWM_BITS=3, STEP_CYCLES=1, one full wheel. Required: latched duties follow the S0..S5 table, and every sector transition keeps all three duties continuous (e.g. S0→S1: G goes 7→7 and R stays 7).
- **Illegal sector recovery.** Force `sector`=6 and let it run. Required: the next `tick` yields sector 0, ramp 0.
